ref_fetch: RTL and testbench

REF_FETCH -- requirements
Module: ref_fetch

---
 rtl/me_pkg.sv | 14 +
 rtl/ref_fetch_if.sv | 27 ++
 rtl/ref_fifo.sv | 51 +++++
 rtl/ref_fetch.sv | 131 +++++++++++++
 tb/tb_ref_fetch.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared widths and FSM encoding for the reference-fetch block.
package me_pkg;

   localparam int unsigned REF_WORD_W  = 64;
   localparam int unsigned MEM_ADDR_W  = 32;
   localparam int unsigned NUM_WORDS_W = 20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ref_fetch_if.sv
// Memory read request/response channel between ref_fetch and the memory port.
interface ref_fetch_if;
   import me_pkg::*;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [MEM_ADDR_W-1:0] mem_req_addr;
   logic                  mem_rsp_valid;
   logic [REF_WORD_W-1:0] mem_rsp_data;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_data
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_data
   );

endinterface

// File: rtl/ref_fifo.sv
// Show-ahead synchronous FIFO; head reads zero while empty.
module ref_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
   assign pop_ok  = pop_i && (count_q != '0);

   // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ref_fetch.sv
// Reference-word prefetcher: issues credit-limited memory reads and streams data to the SRAM stage.
module ref_fetch
   import me_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_STEP  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [MEM_ADDR_W-1:0]  base_addr,
   input  logic [NUM_WORDS_W-1:0] num_words,
   ref_fetch_if.master            mem,
   input  logic                   sram_wr_active,
   input  logic                   ds_stall,
   output logic [REF_WORD_W-1:0]  ref_in,
   output logic                   ref_en,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_e           state_q, state_d;
   logic [NUM_WORDS_W-1:0] num_q, num_d;
   logic [NUM_WORDS_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0]       out_q, out_d;
   logic [MEM_ADDR_W-1:0]  addr_q, addr_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;
   logic                   busy_q;

   logic                   issue;
   logic                   rsp_push;
   logic                   pop;
   logic [CNT_W-1:0]       fifo_cnt;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       occ_d;
   logic [SUM_W-1:0]       credit_sum;

   assign issue    = valid_q && mem.mem_req_ready;
   assign rsp_push = mem.mem_rsp_valid && (state_q != ST_IDLE);
   assign ref_en   = busy_q && !ds_stall && (!sram_wr_active || !fifo_empty);
   assign pop      = ref_en && sram_wr_active;

   ref_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REF_WORD_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_push),
      .data_i  (mem.mem_rsp_data),
      .pop_i   (pop),
      .head_o  (ref_in),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: leave FETCH on the last issue, leave DRAIN once nothing is in flight or buffered.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start && (num_words != '0)) state_d = ST_FETCH;
         ST_FETCH: if (issue && ((issued_q + NUM_WORDS_W'(1)) == num_q)) state_d = ST_DRAIN;
         ST_DRAIN: if ((out_q == '0) && fifo_empty) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs and counters: request valid is precomputed from next-cycle credit so it can be registered.
   always_comb begin
      num_d    = num_q;
      issued_d = issued_q;
      addr_d   = addr_q;
      out_d    = out_q;
      done_d   = 1'b0;
      if ((state_q == ST_IDLE) && start) begin
         num_d    = num_words;
         issued_d = '0;
         out_d    = '0;
         addr_d   = base_addr;
         done_d   = (num_words == '0);
      end else begin
         if (issue) begin
            issued_d = issued_q + NUM_WORDS_W'(1);
            addr_d   = addr_q + MEM_ADDR_W'(ADDR_STEP);
         end
         out_d = out_q + CNT_W'(issue) - CNT_W'(rsp_push);
      end
      if ((state_q == ST_DRAIN) && (state_d == ST_IDLE)) done_d = 1'b1;
      occ_d      = fifo_cnt + CNT_W'(rsp_push) - CNT_W'(pop);
      credit_sum = SUM_W'(out_d) + SUM_W'(occ_d);
      valid_d    = (state_d == ST_FETCH) && (issued_d < num_d) &&
                   (credit_sum < SUM_W'(FIFO_DEPTH));
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         num_q    <= '0;
         issued_q <= '0;
         out_q    <= '0;
         addr_q   <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         num_q    <= num_d;
         issued_q <= issued_d;
         out_q    <= out_d;
         addr_q   <= addr_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         busy_q   <= (state_d != ST_IDLE);
      end
   end

   assign mem.mem_req_valid = valid_q;
   assign mem.mem_req_addr  = addr_q;
   assign busy              = busy_q;
   assign done              = done_q;

endmodule

// File: tb/tb_ref_fetch.sv
// Directed bench for ref_fetch with a transfer-level reference model and memory responder.
module tb_ref_fetch;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned ADDR_STEP  = 8;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [19:0] num_words;
   logic        sram_wr_active;
   logic        ds_stall;
   logic [63:0] ref_in;
   logic        ref_en;
   logic        busy;
   logic        done;

   ref_fetch_if bus ();

   ref_fetch #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_STEP  (ADDR_STEP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_addr      (base_addr),
      .num_words      (num_words),
      .mem            (bus),
      .sram_wr_active (sram_wr_active),
      .ds_stall       (ds_stall),
      .ref_in         (ref_in),
      .ref_en         (ref_en),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // transfer-level model state
   bit          m_active = 1'b0;
   bit          m_done = 1'b0;
   int          m_num = 0;
   int          m_issued = 0;
   int          m_out = 0;
   logic [31:0] m_base = '0;
   logic [63:0] m_q[$];

   // memory responder
   int unsigned cyc = 0;
   int unsigned lat = 2;
   int unsigned rq_due[$];
   logic [63:0] rq_data[$];

   // scenario statistics
   int          n_issue = 0;
   int          n_pop = 0;
   int          done_cnt = 0;
   logic [31:0] last_addr = '0;

   function automatic logic [63:0] word_of(input logic [31:0] a);
      return {a, ~a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive responder, compare DUT with model, advance model.
   task automatic tick();
      logic        exp_valid;
      logic        exp_en;
      logic        issue;
      logic        pop;
      logic        rv;
      logic        next_done;
      logic [31:0] exp_addr;
      logic [63:0] exp_in;
      logic [63:0] rd;
      @(negedge clk);
      rv = 1'b0;
      rd = '0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
         rv = 1'b1;
         rd = rq_data[0];
         void'(rq_due.pop_front());
         void'(rq_data.pop_front());
      end
      bus.mem_rsp_valid = rv;
      bus.mem_rsp_data  = rd;
      #1;
      exp_valid = m_active && (m_issued < m_num) && (m_out + int'(m_q.size()) < int'(FIFO_DEPTH));
      exp_addr  = m_base + 32'(m_issued) * 32'(ADDR_STEP);
      exp_en    = m_active && !ds_stall && (!sram_wr_active || m_q.size() > 0);
      exp_in    = (m_q.size() > 0) ? m_q[0] : 64'd0;
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(m_active));
         chk("done", 64'(done), 64'(m_done));
         chk("req_valid", 64'(bus.mem_req_valid), 64'(exp_valid));
         if (exp_valid) chk("req_addr", 64'(bus.mem_req_addr), 64'(exp_addr));
         chk("ref_en", 64'(ref_en), 64'(exp_en));
         chk("ref_in", ref_in, exp_in);
         if (done === 1'b1) done_cnt++;
      end
      issue = exp_valid && bus.mem_req_ready;
      if (issue) begin
         rq_due.push_back(cyc + lat);
         rq_data.push_back(word_of(exp_addr));
      end
      pop       = exp_en && sram_wr_active;
      next_done = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         m_issued = 0;
         m_out    = 0;
         m_q.delete();
      end else if (!m_active) begin
         if (start) begin
            if (num_words == 20'd0) next_done = 1'b1;
            else begin
               m_active = 1'b1;
               m_num    = int'(num_words);
               m_base   = base_addr;
               m_issued = 0;
               m_out    = 0;
            end
         end
      end else if (m_issued == m_num && m_out == 0 && m_q.size() == 0) begin
         m_active  = 1'b0;
         next_done = 1'b1;
      end else begin
         if (pop) begin
            void'(m_q.pop_front());
            n_pop++;
         end
         if (rv) begin
            m_q.push_back(rd);
            m_out--;
         end
         if (issue) begin
            m_issued++;
            m_out++;
            n_issue++;
            last_addr = exp_addr;
         end
      end
      m_done = next_done;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_idle(input int max);
      int k = 0;
      while (m_active && k < max) begin
         tick();
         k++;
      end
      chk("idle_timeout", 64'(m_active), 64'd0);
   endtask

   task automatic begin_xfer(input logic [31:0] b, input logic [19:0] n);
      n_issue   = 0;
      n_pop     = 0;
      done_cnt  = 0;
      base_addr = b;
      num_words = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      start             = 1'b0;
      base_addr         = '0;
      num_words         = '0;
      sram_wr_active    = 1'b1;
      ds_stall          = 1'b0;
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;

      // reset
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_addr", 64'(bus.mem_req_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ref_in", ref_in, 64'd0);

      // zero-length transfer
      begin_xfer(32'h0000_0500, 20'd0);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_valid", 64'(bus.mem_req_valid), 64'd0);
      tick();
      tick();
      chk("zero_done_cnt", 64'(done_cnt), 64'd1);

      // nominal 23-word stream, with an ignored start while busy
      begin_xfer(32'h0000_1000, 20'd23);
      repeat (4) tick();
      base_addr = 32'h0000_9000;
      num_words = 20'd3;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      run_until_idle(300);
      tick();
      tick();
      chk("nom_issued", 64'(n_issue), 64'd23);
      chk("nom_last_addr", 64'(last_addr), 64'h0000_10B0);
      chk("nom_pops", 64'(n_pop), 64'd23);
      chk("nom_done_cnt", 64'(done_cnt), 64'd1);

      // ready back-pressure across the 32-bit address wrap
      begin_xfer(32'hFFFF_FFC0, 20'd16);
      repeat (4) tick();
      bus.mem_req_ready = 1'b0;
      repeat (5) tick();
      chk("hold_addr", 64'(bus.mem_req_addr), 64'hFFFF_FFE0);
      chk("hold_valid", 64'(bus.mem_req_valid), 64'd1);
      bus.mem_req_ready = 1'b1;
      run_until_idle(300);
      tick();
      tick();
      chk("wrap_issued", 64'(n_issue), 64'd16);
      chk("wrap_last_addr", 64'(last_addr), 64'h0000_0038);
      chk("wrap_pops", 64'(n_pop), 64'd16);
      chk("wrap_done_cnt", 64'(done_cnt), 64'd1);

      // downstream stall fills the credit window
      ds_stall = 1'b1;
      begin_xfer(32'h0000_3000, 20'd20);
      repeat (20) tick();
      chk("stall_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("stall_issued", 64'(n_issue), 64'd8);
      chk("stall_credit", 64'(m_out + int'(m_q.size())), 64'd8);
      chk("stall_ref_en", 64'(ref_en), 64'd0);
      ds_stall = 1'b0;
      run_until_idle(300);
      tick();
      tick();
      chk("stall_issued_all", 64'(n_issue), 64'd20);
      chk("stall_pops", 64'(n_pop), 64'd20);
      chk("stall_done_cnt", 64'(done_cnt), 64'd1);

      // idle-advance cycles: ref_en high, nothing popped
      sram_wr_active = 1'b0;
      begin_xfer(32'h0000_4000, 20'd40);
      repeat (23) tick();
      chk("adv_ref_in", ref_in, 64'h0000_4000_FFFF_BFFF);
      chk("adv_ref_en", 64'(ref_en), 64'd1);
      chk("adv_occ", 64'(m_q.size()), 64'd8);
      chk("adv_pops", 64'(n_pop), 64'd0);
      sram_wr_active = 1'b1;
      run_until_idle(400);
      tick();
      tick();
      chk("adv_pops_all", 64'(n_pop), 64'd40);
      chk("adv_done_cnt", 64'(done_cnt), 64'd1);

      // reset mid-transfer with three reads in flight
      lat = 3;
      begin_xfer(32'h0000_5000, 20'd23);
      for (int k = 0; k < 100 && n_pop < 10; k++) tick();
      chk("abort_pops", 64'(n_pop), 64'd10);
      chk("abort_out", 64'(m_out), 64'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_valid", 64'(bus.mem_req_valid), 64'd0);
      done_cnt = 0;
      repeat (10) tick();
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_late_drained", 64'(rq_due.size()), 64'd0);
      lat = 2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
